// File: rtl/aes128_decipher.sv
// Iterative AES-128 inverse cipher. The last round key is first derived by running the
// forward key schedule. Ten inverse rounds then run, one per clock, while the key schedule
// is unwound back to the cipher key. Buses use FIPS byte order: bit 0 is the MSB of byte 0.
module aes128_decipher (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [0:127] crypte,
  input  logic [0:127] key,
  output logic         ready,
  output logic [0:127] message,
  output logic         done
);

  typedef enum logic [2:0] {
    StIdle,
    StKeyExp,
    StInit,
    StRound,
    StFinal,
    StDone
  } fsm_e;

  // Entry 0 of each table sits in the top byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[11'd2047 - {b, 3'b000} -: 8];
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return INV_SBOX[11'd2047 - {b, 3'b000} -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] rcon_lut(input logic [3:0] r);
    logic [7:0] rc;
    case (r)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

  // SubWord(RotWord(w)) with the round constant folded into the top byte.
  function automatic logic [31:0] key_mix(input logic [31:0] w, input logic [7:0] rc);
    return {sbox(w[23:16]) ^ rc, sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
  endfunction

  function automatic logic [127:0] key_fwd(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] n0, n1, n2, n3;
    n0 = k[127:96] ^ key_mix(k[31:0], rc);
    n1 = k[95:64] ^ n0;
    n2 = k[63:32] ^ n1;
    n3 = k[31:0] ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  // Exact inverse of key_fwd: recovers the previous round key.
  function automatic logic [127:0] key_inv(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] n0, n1, n2, n3;
    n3 = k[31:0] ^ k[63:32];
    n2 = k[63:32] ^ k[95:64];
    n1 = k[95:64] ^ k[127:96];
    n0 = k[127:96] ^ key_mix(n3, rc);
    return {n0, n1, n2, n3};
  endfunction

  // InvShiftRows then InvSubBytes; byte 4c+r is row r of column c.
  function automatic logic [127:0] inv_shift_sub(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127 - 8 * (4 * c + r) -: 8] = inv_sbox(s[127 - 8 * (4 * ((c + 4 - r) % 4) + r) -: 8]);
      end
    end
    return o;
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] w);
    logic [7:0] a   [4];
    logic [7:0] m9  [4];
    logic [7:0] m11 [4];
    logic [7:0] m13 [4];
    logic [7:0] m14 [4];
    logic [7:0] x2, x4, x8;
    logic [31:0] o;
    o = '0;
    for (int i = 0; i < 4; i++) begin
      a[i]   = w[31 - 8 * i -: 8];
      x2     = xtime(a[i]);
      x4     = xtime(x2);
      x8     = xtime(x4);
      m9[i]  = x8 ^ a[i];
      m11[i] = x8 ^ x2 ^ a[i];
      m13[i] = x8 ^ x4 ^ a[i];
      m14[i] = x8 ^ x4 ^ x2;
    end
    for (int r = 0; r < 4; r++) begin
      o[31 - 8 * r -: 8] = m14[r] ^ m11[(r + 1) % 4] ^ m13[(r + 2) % 4] ^ m9[(r + 3) % 4];
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_cols(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      o[127 - 32 * c -: 32] = inv_mix_col(s[127 - 32 * c -: 32]);
    end
    return o;
  endfunction

  fsm_e         fsm_q;
  logic [127:0] state_q;
  logic [127:0] rk_q;
  logic [127:0] ct_hold_q;
  logic [127:0] message_q;
  logic [3:0]   rnd_q;
  logic         ready_q;
  logic         done_q;

  logic [7:0]   rcon;
  logic [127:0] rk_fwd;
  logic [127:0] rk_inv;
  logic [127:0] isb;
  logic [127:0] round_out;

  // Round datapath: rnd_q selects Rcon for both key directions. It rests at 10 during INIT.
  always_comb begin
    rcon      = rcon_lut(rnd_q);
    rk_fwd    = key_fwd(rk_q, rcon);
    rk_inv    = key_inv(rk_q, rcon);
    isb       = inv_shift_sub(state_q);
    round_out = inv_mix_cols(isb ^ rk_q);
  end

  // Control FSM with registered ready/done/message.
  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_q     <= StIdle;
      state_q   <= '0;
      rk_q      <= '0;
      ct_hold_q <= '0;
      message_q <= '0;
      rnd_q     <= '0;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (fsm_q)
        StIdle, StDone: begin
          if (start) begin
            ct_hold_q <= crypte;
            rk_q      <= key;
            rnd_q     <= 4'd1;
            ready_q   <= 1'b0;
            fsm_q     <= StKeyExp;
          end
        end
        StKeyExp: begin
          rk_q <= rk_fwd;
          if (rnd_q == 4'd10) begin
            fsm_q <= StInit;
          end else begin
            rnd_q <= rnd_q + 4'd1;
          end
        end
        StInit: begin
          state_q <= ct_hold_q ^ rk_q;
          rk_q    <= rk_inv;
          rnd_q   <= 4'd9;
          fsm_q   <= StRound;
        end
        StRound: begin
          state_q <= round_out;
          rk_q    <= rk_inv;
          if (rnd_q == 4'd1) begin
            rnd_q <= 4'd0;
            fsm_q <= StFinal;
          end else begin
            rnd_q <= rnd_q - 4'd1;
          end
        end
        StFinal: begin
          message_q <= isb ^ rk_q;
          done_q    <= 1'b1;
          ready_q   <= 1'b1;
          fsm_q     <= StDone;
        end
        default: fsm_q <= StIdle;
      endcase
    end
  end

  assign ready   = ready_q;
  assign done    = done_q;
  assign message = message_q;

endmodule

// File: tb/tb_aes128_decipher.sv
// Self-checking bench for aes128_decipher: FIPS vectors, handshake corner cases and
// random loopback against a behavioural AES-128 encryptor.
module tb_aes128_decipher;

  localparam logic [127:0] C1_KEY  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] B_KEY   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT    = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_PT    = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_RK10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [0:127] crypte;
  logic [0:127] key;
  logic         ready;
  logic [0:127] message;
  logic         done;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] sb [256];

  always #5 clk = ~clk;

  aes128_decipher dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .crypte  (crypte),
    .key     (key),
    .ready   (ready),
    .message (message),
    .done    (done)
  );

  // ---------------- behavioural reference ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  // S-box from first principles: multiplicative inverse followed by the affine map.
  task automatic build_sbox();
    logic [7:0] inv, r, acc;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      r   = inv;
      acc = inv;
      for (int k = 0; k < 4; k++) begin
        r   = {r[6:0], r[7]};
        acc = acc ^ r;
      end
      sb[x] = acc ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] aes_encrypt(input logic [127:0] k, input logic [127:0] pt);
    logic [31:0]  w [44];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   a [4];
    logic [7:0]   rc;
    logic [31:0]  tmp;
    logic [127:0] out;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32 * i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i - 1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sb[tmp[31:24]], sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]]} ^ {rc, 24'h0};
        rc  = gmul(rc, 8'h02);
      end
      w[i] = w[i - 4] ^ tmp;
    end
    for (int i = 0; i < 16; i++) s[i] = pt[127 - 8 * i -: 8] ^ w[i / 4][31 - 8 * (i % 4) -: 8];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int i = 0; i < 16; i++) t[i] = sb[s[i]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) s[4 * c + r] = t[4 * ((c + r) % 4) + r];
      if (rnd < 10) begin
        for (int c = 0; c < 4; c++) begin
          for (int r = 0; r < 4; r++) a[r] = s[4 * c + r];
          for (int r = 0; r < 4; r++)
            t[4 * c + r] = gmul(8'h02, a[r]) ^ gmul(8'h03, a[(r + 1) % 4]) ^
                           a[(r + 2) % 4] ^ a[(r + 3) % 4];
        end
        for (int i = 0; i < 16; i++) s[i] = t[i];
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4 * rnd + i / 4][31 - 8 * (i % 4) -: 8];
    end
    for (int i = 0; i < 16; i++) out[127 - 8 * i -: 8] = s[i];
    return out;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns just after the acceptance edge E0.
  task automatic accept(input logic [127:0] ct, input logic [127:0] k);
    crypte = ct;
    key    = k;
    start  = 1'b1;
    tick();
    start  = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1;
    start = 1'b1;
    crypte = C1_CT;
    key    = C1_KEY;
    tick();
    tick();
    n_checks++;
    if (ready !== 1'b1 || done !== 1'b0 || message !== 128'h0)
      $display("FAIL reset_state ready=%b done=%b message=%h required ready=1 done=0 message=0",
               ready, done, message);
    else n_pass++;
    reset = 1'b0;
    start = 1'b0;
    tick();
    n_checks++;
    if (ready !== 1'b1 || done !== 1'b0)
      $display("FAIL reset_over_start ready=%b done=%b required ready=1 done=0", ready, done);
    else n_pass++;
  endtask

  task automatic test_fips_c1();
    accept(C1_CT, C1_KEY);
    for (int t = 1; t <= 20; t++) begin
      tick();
      n_checks++;
      if (ready !== 1'b0 || done !== 1'b0)
        $display("FAIL c1_busy t=%0d ready=%b done=%b required ready=0 done=0", t, ready, done);
      else n_pass++;
    end
    tick();
    n_checks++;
    if (done !== 1'b1 || ready !== 1'b1 || message !== C1_PT)
      $display("FAIL c1_result done=%b ready=%b message=%h required done=1 ready=1 message=%h",
               done, ready, message, C1_PT);
    else n_pass++;
    tick();
    n_checks++;
    if (done !== 1'b0 || message !== C1_PT)
      $display("FAIL c1_hold done=%b message=%h required done=0 message=%h",
               done, message, C1_PT);
    else n_pass++;
  endtask

  task automatic test_appendix_b();
    accept(B_CT, B_KEY);
    repeat (10) tick();
    n_checks++;
    if (dut.rk_q !== B_RK10)
      $display("FAIL b_rk_init rk=%h required %h", dut.rk_q, B_RK10);
    else n_pass++;
    repeat (11) tick();
    n_checks++;
    if (done !== 1'b1 || message !== B_PT)
      $display("FAIL b_result done=%b message=%h required done=1 message=%h",
               done, message, B_PT);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    accept(C1_CT, C1_KEY);
    repeat (21) tick();
    n_checks++;
    if (done !== 1'b1 || message !== C1_PT)
      $display("FAIL b2b_first done=%b message=%h required done=1 message=%h",
               done, message, C1_PT);
    else n_pass++;
    accept(B_CT, B_KEY);
    n_checks++;
    if (ready !== 1'b0 || done !== 1'b0 || message !== C1_PT)
      $display("FAIL b2b_accept ready=%b done=%b message=%h required ready=0 done=0 message=%h",
               ready, done, message, C1_PT);
    else n_pass++;
    for (int t = 1; t <= 20; t++) begin
      tick();
      n_checks++;
      if (done !== 1'b0 || message !== C1_PT)
        $display("FAIL b2b_stable t=%0d done=%b message=%h required done=0 message=%h",
                 t, done, message, C1_PT);
      else n_pass++;
    end
    tick();
    n_checks++;
    if (done !== 1'b1 || message !== B_PT)
      $display("FAIL b2b_second done=%b message=%h required done=1 message=%h",
               done, message, B_PT);
    else n_pass++;
  endtask

  task automatic test_busy_start();
    accept(C1_CT, C1_KEY);
    for (int t = 1; t <= 20; t++) begin
      tick();
      n_checks++;
      if (ready !== 1'b0 || done !== 1'b0)
        $display("FAIL busy_ready t=%0d ready=%b done=%b required ready=0 done=0", t, ready, done);
      else n_pass++;
      if (t == 4 || t == 14) begin
        start  = 1'b1;
        crypte = {$urandom(), $urandom(), $urandom(), $urandom()};
        key    = {$urandom(), $urandom(), $urandom(), $urandom()};
      end else begin
        start = 1'b0;
      end
    end
    tick();
    n_checks++;
    if (done !== 1'b1 || message !== C1_PT)
      $display("FAIL busy_result done=%b message=%h required done=1 message=%h",
               done, message, C1_PT);
    else n_pass++;
    repeat (3) begin
      tick();
      n_checks++;
      if (done !== 1'b0 || ready !== 1'b1)
        $display("FAIL busy_after done=%b ready=%b required done=0 ready=1", done, ready);
      else n_pass++;
    end
  endtask

  task automatic test_mid_reset();
    accept(C1_CT, C1_KEY);
    repeat (12) tick();
    reset = 1'b1;
    tick();
    n_checks++;
    if (ready !== 1'b1 || done !== 1'b0 || message !== 128'h0)
      $display("FAIL midrst_state ready=%b done=%b message=%h required ready=1 done=0 message=0",
               ready, done, message);
    else n_pass++;
    reset = 1'b0;
    for (int t = 0; t < 30; t++) begin
      tick();
      n_checks++;
      if (done !== 1'b0 || message !== 128'h0)
        $display("FAIL midrst_quiet t=%0d done=%b message=%h required done=0 message=0",
                 t, done, message);
      else n_pass++;
    end
    accept(C1_CT, C1_KEY);
    repeat (21) tick();
    n_checks++;
    if (done !== 1'b1 || message !== C1_PT)
      $display("FAIL midrst_fresh done=%b message=%h required done=1 message=%h",
               done, message, C1_PT);
    else n_pass++;
  endtask

  task automatic test_loopback(input int n);
    logic [127:0] k, pt, ct;
    int           lat;
    bit           found;
    for (int j = 0; j < n; j++) begin
      k   = {$urandom(), $urandom(), $urandom(), $urandom()};
      pt  = {$urandom(), $urandom(), $urandom(), $urandom()};
      ct  = aes_encrypt(k, pt);
      accept(ct, k);
      found = 1'b0;
      lat   = 0;
      for (int t = 1; t <= 40 && !found; t++) begin
        tick();
        if (done === 1'b1) begin
          found = 1'b1;
          lat   = t;
        end
      end
      n_checks++;
      if (!found || lat != 21 || message !== pt)
        $display("FAIL loopback j=%0d seen=%0d latency=%0d message=%h required latency=21 message=%h",
                 j, found, lat, message, pt);
      else n_pass++;
    end
  endtask

  initial begin
    reset  = 1'b0;
    start  = 1'b0;
    crypte = '0;
    key    = '0;
    build_sbox();
    test_reset();
    test_fips_c1();
    test_appendix_b();
    test_back_to_back();
    test_busy_start();
    test_mid_reset();
    test_loopback(1000);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/aes128_decipher.md
# aes128_decipher

Iterative AES-128 inverse cipher (FIPS-197 §5.3), the decrypt counterpart of the AES-128 encryption datapath. It accepts a 128-bit ciphertext and the original 128-bit cipher key, derives the last round key by running the forward key schedule, then performs ten inverse rounds while unwinding the key schedule on the fly. One round is computed per clock, with a start/ready/done handshake; it sits beside the encryptor in the same clock domain.

## Interface
- No parameters; fixed AES-128 (Nk=4, Nr=10).
- clk  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high; sampled on the clk rising edge.
- start  in  1  request; accepted only on a cycle where start=1 and ready=1.
- crypte  in  [0:127]  ciphertext; bit 0 is the MSB of state byte 0 (FIPS byte order). Sampled at acceptance.
- key  in  [0:127]  cipher key, same bit/byte order. Sampled at acceptance.
- ready  out  1  high in IDLE and DONE; low while busy.
- message  out  [0:127]  recovered plaintext; registered; held until the next acceptance.
- done  out  1  one-cycle pulse when message becomes valid.

## Operation
- Internal registers:
  - state: 128 bits.
  - rk: 128-bit round key.
  - ct_hold: 128 bits.
  - rnd: 4-bit counter.
  - fsm: IDLE, KEYEXP, INIT, ROUND, FINAL, DONE.
- IDLE / DONE:
  - ready=1.
  - On start, capture ct_hold←crypte, rk←key, rnd←1, and go to KEYEXP.
  - start while ready=0 is ignored; there is no queuing.
- KEYEXP (10 cycles, rnd=1..10), each cycle:
  - rk←forward_step(rk, Rcon[rnd]).
  - rnd increments.
  - On rnd=10, go to INIT. rk then holds round key 10.
- INIT (1 cycle):
  - state←ct_hold^rk.
  - rk←inverse_step(rk, Rcon[10]), i.e. round key 9.
  - rnd←9, then go to ROUND.
- ROUND (9 cycles, rnd=9..1), each cycle:
  - state←InvMixColumns(InvSubBytes(InvShiftRows(state))^rk).
  - rk←inverse_step(rk, Rcon[rnd]).
  - rnd decrements.
  - After rnd=1, go to FINAL.
- FINAL (1 cycle):
  - message←InvSubBytes(InvShiftRows(state))^rk, where rk is round key 0 and equals the captured key.
  - done←1, then go to DONE.
- DONE behaves as IDLE. done is high only in the first DONE cycle.
- Key steps (words w0..w3):
  - forward_step: w0'=w0^SubWord(RotWord(w3))^Rcon; wi'=wi^w(i-1)' for i=1..3.
  - inverse_step: w3'=w3^w2, w2'=w2^w1, w1'=w1^w0; w0'=w0^SubWord(RotWord(w3'))^Rcon.
  - Rcon[1..10]=01,02,04,08,10,20,40,80,1b,36, placed in the MSB byte.
- S-box and inverse S-box are combinational lookups (16 SubBytes instances and 4 SubWord instances).
- All GF(2^8) arithmetic is modulo x^8+x^4+x^3+x+1.
- InvMixColumns coefficients: 0e, 0b, 0d, 09.
- Reset, including mid-operation:
  - fsm←IDLE, rnd←0, state/rk/ct_hold/message←0, done←0, ready←1.
  - Any in-flight job is discarded with no done pulse.
  - reset has priority over start in the same cycle.

## Timing
- Acceptance edge is E0.
- KEYEXP occupies E1..E10, INIT E11, ROUND E12..E20, FINAL E21.
- message is valid and done=1 in the cycle after E21 (22 cycles after acceptance).
- ready returns high in that same cycle, so back-to-back throughput is one block per 22 cycles.
- A start asserted in the done cycle is accepted; message and done for the old block stay visible during that cycle.
- message changes only at a FINAL edge or on reset. Inputs crypte/key may change freely after E0.

## Test plan
- FIPS-197 C.1: key=000102030405060708090a0b0c0d0e0f, crypte=69c4e0d86a7b0430d8cdb78070b4c55a → message=00112233445566778899aabbccddeeff. done pulses exactly once, 22 cycles after acceptance.
- FIPS-197 Appendix B: key=2b7e151628aed2a6abf7158809cf4f3c, crypte=3925841d02dc09fbdc118597196a0b32 → message=3243f6a8885a308d313198a2e0370734. Internal rk at INIT entry = d014f9a8c9ee2589e13f0cc8b6630ca6.
- Back-to-back: assert start in the done cycle of the C.1 job with the Appendix B vector → second done 22 cycles later with the correct plaintext. First message stable until then.
- Busy start: pulse start with garbage inputs at E5 and E15 of a C.1 job → ignored; result unchanged; ready=0 throughout E1..E21.
- Mid-operation reset: reset at E13 → next cycle ready=1, message=0, done=0. No done pulse follows. A fresh C.1 job afterwards decrypts correctly.
- Loopback: 1000 random key/plaintext pairs encrypted by the encryptor, then fed here → plaintext recovered bit-exact every time.
